otg_hpi_access_ctrl: RTL and testbench
======================================

OTG_HPI_ACCESS_CTRL -- requirements
Module: otg_hpi_access_ctrl

Interface
REQ-001 SHALL provide parameter STROBE_CYC, default 4: cycles rd_n/wr_n held low per HPI access; legal range 1..255.
REQ-002 SHALL provide parameter RECOVER_CYC, default 2: cycles cs_n held high between HPI accesses; legal range 1..255.
REQ-003 SHALL provide clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL provide reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide req_valid  input  1  request present.
REQ-006 SHALL provide req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL provide req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL provide req_addr  input  16  chip memory byte address.
REQ-009 SHALL provide req_wdata  input  16  write data.
REQ-010 SHALL provide rsp_valid  output  1  one-cycle completion pulse, for reads and writes.
REQ-011 SHALL provide rsp_rdata  output  16  read data.
REQ-012 SHALL provide hpi_addr  output  2  HPI port select: 0 = data, 2 = address.
REQ-013 SHALL provide hpi_cs_n, hpi_rd_n, hpi_wr_n  output  1 each  HPI strobes, active-low.
REQ-014 SHALL provide hpi_dout  output  16, hpi_oe  output  1, hpi_din  input  16  HPI data bus; hpi_oe = 1 drives hpi_dout.

Function
REQ-015 SHALL implement states IDLE, A_SETUP, A_STROBE, A_HOLD, A_RECOVER, D_SETUP, D_STROBE, D_HOLD, D_RECOVER.
REQ-016 req_ready SHALL be 1 only in IDLE; on acceptance, latch req_write, req_addr and req_wdata, then go to A_SETUP (autoinc hit: see REQ-026).
REQ-017 Address phase: hpi_addr = 2, hpi_oe = 1, hpi_dout = latched address for A_SETUP, A_STROBE and A_HOLD.
REQ-018 Address phase timing: A_SETUP 1 cycle with cs_n = 0; A_STROBE STROBE_CYC cycles with wr_n = 0; A_HOLD 1 cycle with strobes high and cs_n = 0; A_RECOVER RECOVER_CYC cycles with cs_n = 1 and hpi_oe = 0.
REQ-019 Data phase: D_* states follow the REQ-018 timing with hpi_addr = 0.
REQ-020 Data phase, write: wr_n = 0 in D_STROBE, hpi_oe = 1, hpi_dout = latched wdata.
REQ-021 Data phase, read: rd_n = 0 in D_STROBE and hpi_oe = 0 throughout the data phase.
REQ-022 Read data SHALL be captured from hpi_din at the edge ending the last D_STROBE cycle; rsp_rdata holds until the next read capture and is unchanged by writes.
REQ-023 At D_RECOVER end, return to IDLE with rsp_valid = 1 for exactly that one IDLE cycle; a new request may be accepted in the same cycle.
REQ-024 Full-access latency, from acceptance edge to the edge asserting rsp_valid: 2*STROBE_CYC + 2*RECOVER_CYC + 4 cycles (16 at defaults).
REQ-025 rd_n and wr_n SHALL never be low simultaneously; cs_n SHALL be low whenever either strobe is low; all strobe outputs SHALL be registered.

Reset
REQ-026 (Autoinc skip, macro defined only) If last_valid && req_addr == last_addr + 2 (16-bit wrap), acceptance SHALL go directly to D_SETUP; latency STROBE_CYC + RECOVER_CYC + 2.
REQ-027 reset_n low SHALL asynchronously force: state IDLE, hpi_cs_n/rd_n/wr_n = 1, hpi_oe = 0, hpi_addr = 0, hpi_dout = 0, rsp_valid = 0, rsp_rdata = 0, last_valid = 0, counters 0.
REQ-028 Reset mid-access SHALL abort without rsp_valid; req_ready = 1 from the first edge after release.

Configuration
REQ-029 Macro OTG_HPI_ACCESS_CTRL_AUTOINC_EN defined: track last_addr/last_valid, update both at every data-phase completion, and apply REQ-026.
REQ-030 OTG_HPI_ACCESS_CTRL_AUTOINC_EN undefined: no last_addr/last_valid logic; every access performs the address phase.

Verification
REQ-031 Defaults, write 0x1234 to 0x0140: hpi_addr = 2 with hpi_dout = 0x0140, then hpi_addr = 0 with hpi_dout = 0x1234; wr_n low 4 cycles per phase; rsp_valid 16 edges after acceptance.
REQ-032 Read 0x0142, hpi_din = 0xBEEF: address phase write, then rd_n low 4 cycles with hpi_oe = 0; rsp_rdata = 0xBEEF with rsp_valid.
REQ-033 AUTOINC_EN, write 0x0140 then 0x0142 back-to-back: second access has no hpi_addr = 2 phase and rsp_valid after 8 edges; then 0x0200 takes a full 16-cycle access.
REQ-034 AUTOINC_EN, last address 0xFFFE, request 0x0000: address phase skipped (wrap).
REQ-035 reset_n pulsed during D_STROBE: strobes/cs_n high and hpi_oe 0 immediately, no rsp_valid; next request to last_addr + 2 performs a full address phase.
REQ-036 req_valid held high through a busy access: req_ready = 0 and no second latch until the rsp_valid cycle; second request accepted on that edge.

Source files
------------

// File: rtl/otg_hpi_access_ctrl.sv
// Sequences one 16-bit chip-memory access over the OTG HPI port: address phase, then data phase.
// Define OTG_HPI_ACCESS_CTRL_AUTOINC_EN to skip the address phase for sequential (addr + 2) accesses.
module otg_hpi_access_ctrl #(
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic [15:0] hpi_dout,
  output logic        hpi_oe,
  input  logic [15:0] hpi_din
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, A_RECOVER,
    D_SETUP, D_STROBE, D_HOLD, D_RECOVER
  } state_t;

  localparam logic [7:0] STROBE_LOAD  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] RECOVER_LOAD = 8'(RECOVER_CYC - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic        lat_write, write_next;
  logic [15:0] lat_addr, addr_next;
  logic [15:0] lat_wdata, wdata_next;
  logic        accept;
  logic        autoinc_hit;
  logic        cs_n_next, rd_n_next, wr_n_next, oe_next;
  logic [1:0]  haddr_next;
  logic [15:0] dout_next;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef OTG_HPI_ACCESS_CTRL_AUTOINC_EN
  logic [15:0] last_addr;
  logic        last_valid;

  assign autoinc_hit = last_valid && (req_addr == last_addr + 16'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_addr  <= 16'd0;
      last_valid <= 1'b0;
    end else if (state == D_RECOVER && cnt == 8'd0) begin
      last_addr  <= lat_addr;
      last_valid <= 1'b1;
    end
  end
`else
  assign autoinc_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    write_next = lat_write;
    addr_next  = lat_addr;
    wdata_next = lat_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          write_next = req_write;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          state_next = autoinc_hit ? D_SETUP : A_SETUP;
        end
      end
      A_SETUP: begin
        state_next = A_STROBE;
        cnt_next   = STROBE_LOAD;
      end
      A_STROBE: begin
        if (cnt == 8'd0) state_next = A_HOLD;
        else             cnt_next   = cnt - 8'd1;
      end
      A_HOLD: begin
        state_next = A_RECOVER;
        cnt_next   = RECOVER_LOAD;
      end
      A_RECOVER: begin
        if (cnt == 8'd0) state_next = D_SETUP;
        else             cnt_next   = cnt - 8'd1;
      end
      D_SETUP: begin
        state_next = D_STROBE;
        cnt_next   = STROBE_LOAD;
      end
      D_STROBE: begin
        if (cnt == 8'd0) state_next = D_HOLD;
        else             cnt_next   = cnt - 8'd1;
      end
      D_HOLD: begin
        state_next = D_RECOVER;
        cnt_next   = RECOVER_LOAD;
      end
      D_RECOVER: begin
        if (cnt == 8'd0) state_next = IDLE;
        else             cnt_next   = cnt - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every HPI strobe comes straight off a flop.
  always_comb begin
    cs_n_next  = 1'b1;
    rd_n_next  = 1'b1;
    wr_n_next  = 1'b1;
    oe_next    = 1'b0;
    haddr_next = 2'd0;
    dout_next  = hpi_dout;
    case (state_next)
      A_SETUP, A_HOLD: begin
        cs_n_next  = 1'b0;
        oe_next    = 1'b1;
        haddr_next = 2'd2;
        dout_next  = addr_next;
      end
      A_STROBE: begin
        cs_n_next  = 1'b0;
        wr_n_next  = 1'b0;
        oe_next    = 1'b1;
        haddr_next = 2'd2;
        dout_next  = addr_next;
      end
      A_RECOVER: haddr_next = 2'd2;
      D_SETUP, D_HOLD: begin
        cs_n_next = 1'b0;
        oe_next   = write_next;
        if (write_next) dout_next = wdata_next;
      end
      D_STROBE: begin
        cs_n_next = 1'b0;
        oe_next   = write_next;
        if (write_next) begin
          wr_n_next = 1'b0;
          dout_next = wdata_next;
        end else begin
          rd_n_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      lat_write <= 1'b0;
      lat_addr  <= 16'd0;
      lat_wdata <= 16'd0;
      hpi_cs_n  <= 1'b1;
      hpi_rd_n  <= 1'b1;
      hpi_wr_n  <= 1'b1;
      hpi_oe    <= 1'b0;
      hpi_addr  <= 2'd0;
      hpi_dout  <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      lat_write <= write_next;
      lat_addr  <= addr_next;
      lat_wdata <= wdata_next;
      hpi_cs_n  <= cs_n_next;
      hpi_rd_n  <= rd_n_next;
      hpi_wr_n  <= wr_n_next;
      hpi_oe    <= oe_next;
      hpi_addr  <= haddr_next;
      hpi_dout  <= dout_next;
      rsp_valid <= (state == D_RECOVER) && (cnt == 8'd0);
      if (state == D_STROBE && cnt == 8'd0 && !lat_write)
        rsp_rdata <= hpi_din;
    end
  end

endmodule

// File: tb/tb_otg_hpi_access_ctrl.sv
// Directed bench for otg_hpi_access_ctrl at default parameters; expectations follow
// OTG_HPI_ACCESS_CTRL_AUTOINC_EN when the bench is built with that macro.
module tb_otg_hpi_access_ctrl;

`ifdef OTG_HPI_ACCESS_CTRL_AUTOINC_EN
  localparam int SEQ_LAT = 8;
  localparam int SEQ_ACYC = 0;
  localparam int SEQ_AWR = 0;
`else
  localparam int SEQ_LAT = 16;
  localparam int SEQ_ACYC = 6;
  localparam int SEQ_AWR = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_oe;
  logic [15:0] hpi_dout;
  logic [15:0] hpi_din = 16'd0;

  int checks = 0;
  int errors = 0;
  int lat, a_cyc, a_wr, d_wr, d_rd, bad, rd_oe_bad, ready_early, accept_wait;
  logic [15:0] a_dout, d_dout;

  otg_hpi_access_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n),
    .hpi_dout(hpi_dout), .hpi_oe(hpi_oe), .hpi_din(hpi_din)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one access from presentation to rsp_valid, tallying what the HPI pins did.
  // With hold set, req_valid stays high carrying the follow-on request.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] din, input logic hold, input logic [15:0] hold_addr,
                               input logic [15:0] hold_wdata);
    int  n;
    logic done;
    if (!req_valid) @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; hpi_din = din;
    a_cyc = 0; a_wr = 0; d_wr = 0; d_rd = 0; bad = 0; rd_oe_bad = 0; ready_early = 0;
    a_dout = 16'hxxxx; d_dout = 16'hxxxx;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    accept_wait = n;
    if (n >= 100) checkOutput("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (hold) begin
      req_write = 1'b1; req_addr = hold_addr; req_wdata = hold_wdata;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0;
    done = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (!hpi_wr_n && !hpi_rd_n) bad++;
      if ((!hpi_wr_n || !hpi_rd_n) && hpi_cs_n) bad++;
      if (hpi_addr == 2'd2 && !hpi_cs_n) a_cyc++;
      if (hpi_addr == 2'd2 && !hpi_wr_n) begin a_wr++; a_dout = hpi_dout; if (!hpi_oe) bad++; end
      if (hpi_addr == 2'd0 && !hpi_wr_n) begin d_wr++; d_dout = hpi_dout; if (!hpi_oe) bad++; end
      if (!hpi_rd_n) begin d_rd++; if (hpi_oe) rd_oe_bad++; end
      if (req_ready && !rsp_valid) ready_early++;
      if (rsp_valid) done = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        n++;
      end
    end
    if (!done) checkOutput("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int n;
    int rsp_cnt;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_cs_n", {31'd0, hpi_cs_n}, 32'd1);
    checkOutput("rst_rd_n", {31'd0, hpi_rd_n}, 32'd1);
    checkOutput("rst_wr_n", {31'd0, hpi_wr_n}, 32'd1);
    checkOutput("rst_oe", {31'd0, hpi_oe}, 32'd0);
    checkOutput("rst_addr", {30'd0, hpi_addr}, 32'd0);
    checkOutput("rst_dout", {16'd0, hpi_dout}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    reset_n = 1'b1;

    $display("[TB] write 0x1234 -> 0x0140");
    applyStimulus(1'b1, 16'h0140, 16'h1234, 16'h0000, 1'b0, 16'h0, 16'h0);
    checkOutput("w0_lat", lat, 32'd16);
    checkOutput("w0_acyc", a_cyc, 32'd6);
    checkOutput("w0_awr", a_wr, 32'd4);
    checkOutput("w0_adout", {16'd0, a_dout}, 32'h0140);
    checkOutput("w0_dwr", d_wr, 32'd4);
    checkOutput("w0_ddout", {16'd0, d_dout}, 32'h1234);
    checkOutput("w0_drd", d_rd, 32'd0);
    checkOutput("w0_bad", bad, 32'd0);
    checkOutput("w0_rdata", {16'd0, rsp_rdata}, 32'h0000);

    $display("[TB] read 0x0142, din 0xBEEF");
    applyStimulus(1'b0, 16'h0142, 16'h0000, 16'hBEEF, 1'b0, 16'h0, 16'h0);
    checkOutput("r0_lat", lat, SEQ_LAT);
    checkOutput("r0_acyc", a_cyc, SEQ_ACYC);
    checkOutput("r0_awr", a_wr, SEQ_AWR);
    checkOutput("r0_drd", d_rd, 32'd4);
    checkOutput("r0_dwr", d_wr, 32'd0);
    checkOutput("r0_rd_oe", rd_oe_bad, 32'd0);
    checkOutput("r0_bad", bad, 32'd0);
    checkOutput("r0_rdata", {16'd0, rsp_rdata}, 32'hBEEF);

    $display("[TB] write 0x5A5A -> 0x0200");
    applyStimulus(1'b1, 16'h0200, 16'h5A5A, 16'h0000, 1'b0, 16'h0, 16'h0);
    checkOutput("w1_lat", lat, 32'd16);
    checkOutput("w1_acyc", a_cyc, 32'd6);
    checkOutput("w1_ddout", {16'd0, d_dout}, 32'h5A5A);
    checkOutput("w1_rdata_kept", {16'd0, rsp_rdata}, 32'hBEEF);

    $display("[TB] wrap 0xFFFE -> 0x0000");
    applyStimulus(1'b1, 16'hFFFE, 16'h0F0F, 16'h0000, 1'b0, 16'h0, 16'h0);
    checkOutput("w2_lat", lat, 32'd16);
    checkOutput("w2_adout", {16'd0, a_dout}, 32'hFFFE);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 16'h0, 16'h0);
    checkOutput("r1_lat", lat, SEQ_LAT);
    checkOutput("r1_acyc", a_cyc, SEQ_ACYC);
    checkOutput("r1_rdata", {16'd0, rsp_rdata}, 32'h1111);

    $display("[TB] req_valid held through busy access");
    applyStimulus(1'b1, 16'h0500, 16'hAAAA, 16'h0000, 1'b1, 16'h0600, 16'h7777);
    checkOutput("h0_ready_early", ready_early, 32'd0);
    checkOutput("h0_adout", {16'd0, a_dout}, 32'h0500);
    checkOutput("h0_ddout", {16'd0, d_dout}, 32'hAAAA);
    checkOutput("h0_lat", lat, 32'd16);
    applyStimulus(1'b1, 16'h0600, 16'h7777, 16'h0000, 1'b0, 16'h0, 16'h0);
    checkOutput("h1_accept_wait", accept_wait, 32'd0);
    checkOutput("h1_adout", {16'd0, a_dout}, 32'h0600);
    checkOutput("h1_ddout", {16'd0, d_dout}, 32'h7777);
    checkOutput("h1_lat", lat, 32'd16);

    $display("[TB] reset during data strobe");
    applyStimulus(1'b1, 16'h0400, 16'h2468, 16'h0000, 1'b0, 16'h0, 16'h0);
    checkOutput("p0_lat", lat, 32'd16);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0402; req_wdata = 16'h1357;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!(hpi_addr == 2'd0 && !hpi_wr_n) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("p1_reach_dstrobe", {31'd0, hpi_wr_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("p1_abort_wr_n", {31'd0, hpi_wr_n}, 32'd1);
    checkOutput("p1_abort_cs_n", {31'd0, hpi_cs_n}, 32'd1);
    checkOutput("p1_abort_oe", {31'd0, hpi_oe}, 32'd0);
    checkOutput("p1_abort_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("p1_ready_after", {31'd0, req_ready}, 32'd1);
    rsp_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    checkOutput("p1_no_rsp", rsp_cnt, 32'd0);
    applyStimulus(1'b1, 16'h0402, 16'h1357, 16'h0000, 1'b0, 16'h0, 16'h0);
    checkOutput("p2_lat", lat, 32'd16);
    checkOutput("p2_acyc", a_cyc, 32'd6);
    checkOutput("p2_adout", {16'd0, a_dout}, 32'h0402);
    checkOutput("p2_ddout", {16'd0, d_dout}, 32'h1357);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
